// File: rtl/lc3b_types.sv
// Shared types for the LC-3b memory hierarchy: machine word, cache line and
// the cache-to-memory arbiter state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/arbiter_control.sv
// Round-robin grant FSM for the I/D-cache memory arbiter: holds the state and
// last-grant registers and decodes the memory strobes and per-cache responses.
module arbiter_control
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       icache_read,
  input  logic       icache_write,
  input  logic       dcache_read,
  input  logic       dcache_write,
  input  logic       pmem_resp,
  output arb_state_t state,
  output logic       pmem_read,
  output logic       pmem_write,
  output logic       icache_resp,
  output logic       dcache_resp
);

  arb_state_t next_state;
  logic       last_grant;
  logic       i_req;
  logic       d_req;

  assign i_req = icache_read | icache_write;
  assign d_req = dcache_read | dcache_write;

  // state and last-grant registers; last_grant only moves when a grant is issued
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
    end else begin
      state <= next_state;
      if ((state == IDLE) && (next_state != IDLE)) begin
        last_grant <= (next_state == SERVE_D) ? GRANT_D : GRANT_I;
      end else begin
        last_grant <= last_grant;
      end
    end
  end

  // next-state and output decode; a simultaneous read+write resolves to a read
  always_comb begin
    next_state  = state;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    icache_resp = 1'b0;
    dcache_resp = 1'b0;
    case (state)
      IDLE: begin
        if (i_req && d_req) begin
          next_state = (last_grant == GRANT_D) ? SERVE_I : SERVE_D;
        end else if (i_req) begin
          next_state = SERVE_I;
        end else if (d_req) begin
          next_state = SERVE_D;
        end else begin
          next_state = IDLE;
        end
      end
      SERVE_I: begin
        pmem_read   = icache_read;
        pmem_write  = icache_write & ~icache_read;
        icache_resp = pmem_resp;
        if (pmem_resp) begin
          next_state = IDLE;
        end else begin
          next_state = SERVE_I;
        end
      end
      SERVE_D: begin
        pmem_read   = dcache_read;
        pmem_write  = dcache_write & ~dcache_read;
        dcache_resp = pmem_resp;
        if (pmem_resp) begin
          next_state = IDLE;
        end else begin
          next_state = SERVE_D;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/mux2.sv
// Generic two-input multiplexer: f = sel ? b : a.
module mux2 #(
  parameter int WIDTH = 16
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] f
);

  // select between the two inputs
  always_comb begin
    if (sel) begin
      f = b;
    end else begin
      f = a;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache and D-cache line fills/write-backs onto one physical
// memory port, one transaction at a time, round-robin between the caches.
module cache_mem_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_read,
  input  logic                  icache_write,
  input  logic [ADDR_WIDTH-1:0] icache_address,
  input  logic [LINE_WIDTH-1:0] icache_wdata,
  output logic [LINE_WIDTH-1:0] icache_rdata,
  output logic                  icache_resp,
  input  logic                  dcache_read,
  input  logic                  dcache_write,
  input  logic [ADDR_WIDTH-1:0] dcache_address,
  input  logic [LINE_WIDTH-1:0] dcache_wdata,
  output logic [LINE_WIDTH-1:0] dcache_rdata,
  output logic                  dcache_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  arb_state_t              state;
  logic                    sel_d;
  logic                    active;
  logic [ADDR_WIDTH-1:0]   sel_address;
  logic [LINE_WIDTH-1:0]   sel_wdata;

  arbiter_control u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .icache_read  (icache_read),
    .icache_write (icache_write),
    .dcache_read  (dcache_read),
    .dcache_write (dcache_write),
    .pmem_resp    (pmem_resp),
    .state        (state),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .icache_resp  (icache_resp),
    .dcache_resp  (dcache_resp)
  );

  assign sel_d  = (state == SERVE_D);
  assign active = (state != IDLE);

  mux2 #(.WIDTH(ADDR_WIDTH)) u_addr_mux (
    .sel (sel_d),
    .a   (icache_address),
    .b   (dcache_address),
    .f   (sel_address)
  );

  mux2 #(.WIDTH(LINE_WIDTH)) u_wdata_mux (
    .sel (sel_d),
    .a   (icache_wdata),
    .b   (dcache_wdata),
    .f   (sel_wdata)
  );

  // the memory port is parked at zero while no cache holds the grant
  mux2 #(.WIDTH(ADDR_WIDTH)) u_addr_gate (
    .sel (active),
    .a   ({ADDR_WIDTH{1'b0}}),
    .b   (sel_address),
    .f   (pmem_address)
  );

  mux2 #(.WIDTH(LINE_WIDTH)) u_wdata_gate (
    .sel (active),
    .a   ({LINE_WIDTH{1'b0}}),
    .b   (sel_wdata),
    .f   (pmem_wdata)
  );

  assign icache_rdata = pmem_rdata;
  assign dcache_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter: reset, single requester,
// tie-break, round-robin alternation, reset mid-transaction, read+write conflict.
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         icache_read, icache_write, dcache_read, dcache_write;
  logic [15:0]  icache_address, dcache_address;
  logic [127:0] icache_wdata, dcache_wdata, icache_rdata, dcache_rdata;
  logic         icache_resp, dcache_resp;
  logic         pmem_read, pmem_write, pmem_resp;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata, pmem_rdata;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [127:0] BEEF = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] A5S  = {16{8'hA5}};

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .icache_read(icache_read), .icache_write(icache_write),
    .icache_address(icache_address), .icache_wdata(icache_wdata),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " pmem_read"},    {127'd0, pmem_read},   128'd0);
    chk({tag, " pmem_write"},   {127'd0, pmem_write},  128'd0);
    chk({tag, " pmem_address"}, {112'd0, pmem_address}, 128'd0);
    chk({tag, " pmem_wdata"},   pmem_wdata,            128'd0);
    chk({tag, " icache_resp"},  {127'd0, icache_resp}, 128'd0);
    chk({tag, " dcache_resp"},  {127'd0, dcache_resp}, 128'd0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    icache_read = 1'b0; icache_write = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0;
    icache_address = 16'h0000; dcache_address = 16'h0000;
    icache_wdata = 128'd0; dcache_wdata = 128'd0;
    pmem_rdata = 128'd0; pmem_resp = 1'b0;
    do_reset();

    // 1: quiet after reset
    for (int c = 0; c < 5; c++) begin
      settle();
      chk_idle("reset_idle");
      tick();
    end

    // 2: I-cache alone, memory answers in the third serve cycle
    icache_read = 1'b1; icache_address = 16'h1230;
    settle();
    chk("t2 no strobe yet", {127'd0, pmem_read}, 128'd0);
    tick();
    chk("t2 pmem_read", {127'd0, pmem_read}, 128'd1);
    chk("t2 pmem_address", {112'd0, pmem_address}, {112'd0, 16'h1230});
    chk("t2 pmem_write", {127'd0, pmem_write}, 128'd0);
    tick();
    chk("t2 wait icache_resp", {127'd0, icache_resp}, 128'd0);
    tick();
    pmem_resp = 1'b1; pmem_rdata = BEEF;
    settle();
    chk("t2 icache_resp", {127'd0, icache_resp}, 128'd1);
    chk("t2 icache_rdata", icache_rdata, BEEF);
    chk("t2 dcache_resp", {127'd0, dcache_resp}, 128'd0);
    tick();
    pmem_resp = 1'b0; icache_read = 1'b0;
    settle();
    chk_idle("t2 after");

    // 3: simultaneous requests straight after reset -> I first
    do_reset();
    icache_read = 1'b1; icache_address = 16'h0010;
    dcache_write = 1'b1; dcache_address = 16'h0F80; dcache_wdata = A5S;
    tick();
    chk("t3 first pmem_read", {127'd0, pmem_read}, 128'd1);
    chk("t3 first pmem_write", {127'd0, pmem_write}, 128'd0);
    chk("t3 first address", {112'd0, pmem_address}, {112'd0, 16'h0010});
    pmem_resp = 1'b1; pmem_rdata = 128'h1;
    settle();
    chk("t3 icache_resp", {127'd0, icache_resp}, 128'd1);
    chk("t3 dcache_resp quiet", {127'd0, dcache_resp}, 128'd0);
    tick();
    pmem_resp = 1'b0; icache_read = 1'b0;
    settle();
    chk_idle("t3 gap");
    tick();
    chk("t3 pmem_write", {127'd0, pmem_write}, 128'd1);
    chk("t3 pmem_read", {127'd0, pmem_read}, 128'd0);
    chk("t3 address", {112'd0, pmem_address}, {112'd0, 16'h0F80});
    chk("t3 wdata", pmem_wdata, A5S);
    pmem_resp = 1'b1;
    settle();
    chk("t3 dcache_resp", {127'd0, dcache_resp}, 128'd1);
    chk("t3 icache_resp quiet", {127'd0, icache_resp}, 128'd0);
    tick();
    pmem_resp = 1'b0; dcache_write = 1'b0;
    settle();
    chk_idle("t3 after");

    // 4: both caches request continuously; last grant was D so I leads
    icache_read = 1'b1; icache_address = 16'h2000;
    dcache_read = 1'b1; dcache_address = 16'h3000;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk($sformatf("t4 txn%0d address", t), {112'd0, pmem_address},
          {112'd0, ((t % 2) == 0) ? 16'h2000 : 16'h3000});
      chk($sformatf("t4 txn%0d pmem_read", t), {127'd0, pmem_read}, 128'd1);
      pmem_resp = 1'b1;
      settle();
      chk($sformatf("t4 txn%0d icache_resp", t), {127'd0, icache_resp},
          ((t % 2) == 0) ? 128'd1 : 128'd0);
      chk($sformatf("t4 txn%0d dcache_resp", t), {127'd0, dcache_resp},
          ((t % 2) == 0) ? 128'd0 : 128'd1);
      tick();
      pmem_resp = 1'b0;
      settle();
      chk($sformatf("t4 txn%0d idle gap", t), {127'd0, pmem_read}, 128'd0);
    end
    icache_read = 1'b0; dcache_read = 1'b0;
    tick();

    // 5: reset while serving D; the late memory response must be ignored
    dcache_read = 1'b1; dcache_address = 16'h4440;
    tick();
    chk("t5 serving", {127'd0, pmem_read}, 128'd1);
    chk("t5 address", {112'd0, pmem_address}, {112'd0, 16'h4440});
    tick();
    rst = 1'b1;
    settle();
    chk("t5 no resp yet", {127'd0, dcache_resp}, 128'd0);
    tick();
    rst = 1'b0; dcache_read = 1'b0;
    settle();
    chk_idle("t5 after rst");
    pmem_resp = 1'b1;
    settle();
    chk_idle("t5 late resp");
    tick();
    pmem_resp = 1'b0;
    settle();
    chk_idle("t5 still idle");

    // 6: illegal read+write on D; unaligned address passes through
    dcache_read = 1'b1; dcache_write = 1'b1; dcache_address = 16'h5557;
    tick();
    chk("t6 pmem_read", {127'd0, pmem_read}, 128'd1);
    chk("t6 pmem_write", {127'd0, pmem_write}, 128'd0);
    chk("t6 address", {112'd0, pmem_address}, {112'd0, 16'h5557});
    pmem_resp = 1'b1;
    settle();
    chk("t6 dcache_resp", {127'd0, dcache_resp}, 128'd1);
    tick();
    pmem_resp = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0;
    settle();
    chk_idle("t6 after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
